display_mux_scheduler: RTL



---
 rtl/scoreboard_pkg.sv | 18 +
 rtl/display_mux_scheduler_digit_code_mask.sv | 36 +++
 rtl/display_mux_scheduler.sv | 131 +++++++++++++
 3 files changed

// File: rtl/scoreboard_pkg.sv
// Shared constants and types for the scoreboard display multiplexer.
// Holds the blank code, the sequencer state enum and the digit-count limit.
package scoreboard_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam int         MAX_DIGITS = 8;

  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } state_t;

  // Anything outside 0..9 is sent as the blank code so the decoder goes dark.
  function automatic logic [3:0] bcd_or_blank(input logic [3:0] nib);
    return (nib > 4'd9) ? BLANK_CODE : nib;
  endfunction

endpackage

// File: rtl/display_mux_scheduler_digit_code_mask.sv
// Combinational selection of one shadow nibble and its blanking rules.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module digit_code_mask
  import scoreboard_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W      = 2
) (
  input  logic [4*NUM_DIGITS-1:0] shadow,
  input  logic [IDX_W-1:0]        idx,
  output logic [3:0]              code
);

  logic [3:0] nib;
`ifdef LEADING_ZERO_BLANK_EN
  logic       upper_nonzero;
`endif

  // NOTE: every signal assigned in this block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    nib = BLANK_CODE;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) nib = shadow[4*i +: 4];
    end
    code = bcd_or_blank(nib);
`ifdef LEADING_ZERO_BLANK_EN
    // Digit idx is a leading zero when it and every more significant nibble are zero.
    upper_nonzero = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((IDX_W'(i) >= idx) && (shadow[4*i +: 4] != 4'd0)) upper_nonzero = 1'b1;
    end
    if ((idx != '0) && !upper_nonzero) code = BLANK_CODE;
`endif
  end

endmodule

// File: rtl/display_mux_scheduler.sv
// Time-multiplexes a shared BCD decoder across NUM_DIGITS digits with guard gaps.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (timing unaffected).
module display_mux_scheduler
  import scoreboard_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   n_digit_en,
  output logic                    frame_done
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int MAX_CNT = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  if ((NUM_DIGITS < 2) || (NUM_DIGITS > MAX_DIGITS)) begin : g_bad_num_digits
    $error("display_mux_scheduler: NUM_DIGITS out of range");
  end

  state_t                  state, state_d;
  logic [IDX_W-1:0]        idx, idx_d;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [4*NUM_DIGITS-1:0] pending;
  logic                    pending_valid;

  logic                    frame_end;
  logic [3:0]              code_d;
  logic [3:0]              bcd_d;
  logic [NUM_DIGITS-1:0]   n_en_d;
  logic                    frame_done_d;

  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt + 1'b1;
    case (state)
      GUARD: begin
        if (cnt == GUARD_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (cnt == DWELL_LAST) begin
          state_d = GUARD;
          cnt_d   = '0;
          idx_d   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
      end
      default: begin
        state_d = GUARD;
        cnt_d   = '0;
      end
    endcase
  end

  assign frame_end = (state == SHOW) && (cnt == DWELL_LAST) && (idx == IDX_LAST);

  // Outputs are computed from the next state so they register on the transition edge.
  digit_code_mask #(
    .NUM_DIGITS (NUM_DIGITS),
    .IDX_W      (IDX_W)
  ) u_code_mask (
    .shadow (shadow),
    .idx    (idx_d),
    .code   (code_d)
  );

  always_comb begin
    bcd_d        = BLANK_CODE;
    n_en_d       = '1;
    frame_done_d = 1'b0;
    if (state_d == SHOW) begin
      bcd_d = code_d;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_d == IDX_W'(i)) n_en_d[i] = 1'b0;
      end
      frame_done_d = (idx_d == IDX_LAST) && (cnt_d == DWELL_LAST);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= GUARD;
      idx           <= '0;
      cnt           <= '0;
      shadow        <= {NUM_DIGITS{BLANK_CODE}};
      pending_valid <= 1'b0;
      bcd_out       <= BLANK_CODE;
      n_digit_en    <= '1;
      frame_done    <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      cnt        <= cnt_d;
      bcd_out    <= bcd_d;
      n_digit_en <= n_en_d;
      frame_done <= frame_done_d;
      if (frame_end) begin
        // A load coinciding with the boundary bypasses pending and lands directly.
        if (load) begin
          shadow <= digits_in;
        end else if (pending_valid) begin
          shadow <= pending;
        end
        pending_valid <= 1'b0;
      end else if (load) begin
        pending_valid <= 1'b1;
      end
    end
  end

  // NOTE: the pending data register has no reset; pending_valid alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (load) pending <= digits_in;
  end

endmodule
